v74x139_scan: RTL and testbench

- Parametrised, clocked successor to the 2-to-4 active-low decoder.
- Decodes an SEL_W-bit index into NUM_OUT active-low one-hot outputs, gated by an active-low enable G_L.
- Two modes:
  - direct: registered decode of SEL.
  - scan: an internal prescaled counter steps the active output round-robin. Used for multiplexed display digit strobes and bus-slot selection.

---
 rtl/v74x139_scan_if.sv | 45 ++++
 rtl/v74x139_scan.sv | 103 ++++++++++
 tb/tb_v74x139_scan.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/v74x139_scan_if.sv
// ---------------------------------------------------------------------------
// v74x139_scan_if
//   Bus bundle for the clocked 2-to-4 style decoder with scan mode.
//
//   Signals:
//     G_L   enable, active-low (master -> slave)
//     MODE  0 = direct decode of SEL, 1 = auto scan (master -> slave)
//     SEL   index used in direct mode (master -> slave)
//     Y_L   decoded outputs, active-low, at most one low (slave -> master)
//     CUR   current index register (slave -> master)
//     WRAP  one-cycle pulse when the scan index wraps to 0 (slave -> master)
//
//   Modports:
//     master  the controller driving enable/mode/select
//     slave   the decoder itself
// ---------------------------------------------------------------------------
interface v74x139_scan_if #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4
);
    logic               G_L;
    logic               MODE;
    logic [SEL_W-1:0]   SEL;
    logic [NUM_OUT-1:0] Y_L;
    logic [SEL_W-1:0]   CUR;
    logic               WRAP;

    modport master (
        output G_L,
        output MODE,
        output SEL,
        input  Y_L,
        input  CUR,
        input  WRAP
    );

    modport slave (
        input  G_L,
        input  MODE,
        input  SEL,
        output Y_L,
        output CUR,
        output WRAP
    );
endinterface

// File: rtl/v74x139_scan.sv
// ---------------------------------------------------------------------------
// v74x139_scan
//   Clocked, parametrised successor to the 2-to-4 active-low decoder.
//   An SEL_W-bit index is decoded into NUM_OUT active-low one-hot outputs,
//   gated by the active-low enable G_L (registered, one cycle of latency).
//
//   Direct mode (MODE=0): the index register loads SEL every cycle.
//   Scan mode   (MODE=1): a prescaler of DIV cycles steps the index
//                         round-robin through 0..NUM_OUT-1; WRAP pulses in
//                         the first cycle the index is back at 0.
//
//   Ports:
//     CLK    clock, rising edge
//     RST_L  asynchronous reset, active-low
//     bus    v74x139_scan_if.slave (G_L, MODE, SEL in; Y_L, CUR, WRAP out)
//
//   Every output is a function of registers only; there is no combinational
//   path from any input to any output.
// ---------------------------------------------------------------------------
module v74x139_scan #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned DIV     = 4
) (
    input  logic          CLK,
    input  logic          RST_L,
    v74x139_scan_if.slave bus
);

    // Prescaler is at least one bit wide so DIV=1 still has a legal register.
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PrescMax = PW'(DIV - 1);
    localparam logic [SEL_W-1:0] IdxLast  = SEL_W'(NUM_OUT - 1);

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             en_q, en_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d   = idx_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        en_d    = ~bus.G_L;
        tick    = (presc_q == PrescMax);

        if (!bus.MODE) begin
            // Direct: load raw SEL, even if out of range; prescaler parked at 0
            // so a later switch to scan starts with a full dwell.
            idx_d   = bus.SEL;
            presc_d = '0;
        end else if (!bus.G_L) begin
            if (tick) begin
                presc_d = '0;
                // >= also pulls an out-of-range index (left over from direct
                // mode) back to 0 without flagging a wrap.
                idx_d   = (idx_q >= IdxLast) ? '0 : idx_q + SEL_W'(1);
                wrap_d  = (idx_q == IdxLast);
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        // Scan with G_L high: idx/presc hold, wrap clears (default above).
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            idx_q   <= '0;
            presc_q <= '0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            presc_q <= presc_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded purely from registers
    // -----------------------------------------------------------------------
    always_comb begin
        bus.Y_L = '1;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (en_q && (idx_q == SEL_W'(i))) begin
                bus.Y_L[i] = 1'b0;
            end
        end
    end

    assign bus.CUR  = idx_q;
    assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_v74x139_scan.sv
module tb_v74x139_scan;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       g_l = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    // Three configurations share one stimulus: default, NUM_OUT=3, DIV=1.
    v74x139_scan_if #(.SEL_W(2), .NUM_OUT(4)) if_a ();
    v74x139_scan_if #(.SEL_W(2), .NUM_OUT(3)) if_b ();
    v74x139_scan_if #(.SEL_W(2), .NUM_OUT(4)) if_c ();

    assign if_a.G_L = g_l;  assign if_a.MODE = mode;  assign if_a.SEL = sel;
    assign if_b.G_L = g_l;  assign if_b.MODE = mode;  assign if_b.SEL = sel;
    assign if_c.G_L = g_l;  assign if_c.MODE = mode;  assign if_c.SEL = sel;

    v74x139_scan #(.SEL_W(2), .NUM_OUT(4), .DIV(4)) u_a (.CLK(clk), .RST_L(rst_l), .bus(if_a));
    v74x139_scan #(.SEL_W(2), .NUM_OUT(3), .DIV(4)) u_b (.CLK(clk), .RST_L(rst_l), .bus(if_b));
    v74x139_scan #(.SEL_W(2), .NUM_OUT(4), .DIV(1)) u_c (.CLK(clk), .RST_L(rst_l), .bus(if_c));

    // ---------------- behavioural model ----------------
    // Per instance: index, enabled flag, cycles spent at current index, wrap flag.
    int nout [3] = '{4, 3, 4};
    int dv   [3] = '{4, 4, 1};
    int m_idx [3] = '{0, 0, 0};
    int m_cnt [3] = '{0, 0, 0};
    int m_en  [3] = '{0, 0, 0};
    int m_wrap[3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_l) begin
        for (int j = 0; j < 3; j++) begin
            if (!rst_l) begin
                m_idx[j] <= 0; m_cnt[j] <= 0; m_en[j] <= 0; m_wrap[j] <= 0;
            end else begin
                m_en[j] <= g_l ? 0 : 1;
                if (!mode) begin
                    m_idx[j] <= int'(sel); m_cnt[j] <= 0; m_wrap[j] <= 0;
                end else if (g_l) begin
                    m_wrap[j] <= 0;
                end else if (m_cnt[j] + 1 == dv[j]) begin
                    // Dwell finished: move on; out-of-range goes to slot 0.
                    m_cnt[j]  <= 0;
                    m_idx[j]  <= (m_idx[j] < nout[j]) ? (m_idx[j] + 1) % nout[j] : 0;
                    m_wrap[j] <= (m_idx[j] == nout[j] - 1) ? 1 : 0;
                end else begin
                    m_cnt[j]  <= m_cnt[j] + 1;
                    m_wrap[j] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int j, input int y, input int cur, input int wrap);
        int all1;
        int ey;
        all1 = (1 << nout[j]) - 1;
        ey   = (m_en[j] != 0 && m_idx[j] < nout[j]) ? (all1 & ~(1 << m_idx[j])) : all1;
        check($sformatf("model[%0d].Y_L", j), y, ey);
        check($sformatf("model[%0d].CUR", j), cur, m_idx[j]);
        check($sformatf("model[%0d].WRAP", j), wrap, m_wrap[j]);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check_inst(0, int'(if_a.Y_L), int'(if_a.CUR), int'(if_a.WRAP));
            check_inst(1, int'(if_b.Y_L), int'(if_b.CUR), int'(if_b.WRAP));
            check_inst(2, int'(if_c.Y_L), int'(if_c.CUR), int'(if_c.WRAP));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [3:0] exp_dir [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bit found;

    initial begin
        g_l = 1'b0; mode = 1'b0; sel = 2'd2;
        repeat (2) cyc();
        check("reset Y_L", int'(if_a.Y_L), 'hF);
        check("reset CUR", int'(if_a.CUR), 0);
        rst_l = 1'b1;
        cmp_on = 1'b1;
        cyc();
        check("direct sel2", int'(if_a.Y_L), 'hB);

        // asynchronous reset mid-cycle
        #2 rst_l = 1'b0;
        #1;
        check("async rst Y_L", int'(if_a.Y_L), 'hF);
        check("async rst CUR", int'(if_a.CUR), 0);
        cyc();
        rst_l = 1'b1;

        // direct decode
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cyc();
            check($sformatf("direct sel%0d", s), int'(if_a.Y_L), int'(exp_dir[s]));
        end
        g_l = 1'b1;
        cyc();
        check("direct disable", int'(if_a.Y_L), 'hF);

        // scan default
        g_l = 1'b0; sel = 2'd0;
        cyc();
        mode = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (k == 3)  check("scan k3",  int'(if_a.Y_L), 'hE);
            if (k == 4)  check("scan k4",  int'(if_a.Y_L), 'hD);
            if (k == 8)  check("scan k8",  int'(if_a.Y_L), 'hB);
            if (k == 12) check("scan k12", int'(if_a.Y_L), 'h7);
            if (k == 15) check("scan k15 wrap", int'(if_a.WRAP), 0);
            if (k == 16) begin
                check("scan k16", int'(if_a.Y_L), 'hE);
                check("scan k16 wrap", int'(if_a.WRAP), 1);
            end
            if (k == 17) check("scan k17 wrap", int'(if_a.WRAP), 0);
        end

        // freeze at idx=2, presc=1
        g_l = 1'b1;
        for (int f = 1; f <= 7; f++) begin
            cyc();
            if (f == 1 || f == 7) begin
                check("freeze Y_L", int'(if_a.Y_L), 'hF);
                check("freeze CUR", int'(if_a.CUR), 2);
            end
        end
        g_l = 1'b0;
        cyc(); check("resume 1", int'(if_a.Y_L), 'hB);
        cyc(); check("resume 2", int'(if_a.Y_L), 'hB);
        cyc(); check("resume 3", int'(if_a.Y_L), 'h7);

        // out-of-range on NUM_OUT=3
        mode = 1'b0; sel = 2'd3;
        cyc();
        check("oor Y_L", int'(if_b.Y_L), 'h7);
        check("oor CUR", int'(if_b.CUR), 3);
        mode = 1'b1;
        repeat (3) cyc();
        check("oor hold CUR", int'(if_b.CUR), 3);
        cyc();
        check("oor recover CUR", int'(if_b.CUR), 0);
        check("oor recover Y_L", int'(if_b.Y_L), 'h6);
        check("oor recover WRAP", int'(if_b.WRAP), 0);
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (e == 4) check("oor scan 1", int'(if_b.Y_L), 'h5);
            if (e == 8) check("oor scan 2", int'(if_b.Y_L), 'h3);
            if (e == 12) begin
                check("oor scan wrap Y_L", int'(if_b.Y_L), 'h6);
                check("oor scan WRAP", int'(if_b.WRAP), 1);
            end
        end

        // DIV=1
        mode = 1'b0; sel = 2'd0;
        cyc();
        mode = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("div1 CUR", int'(if_c.CUR), k % 4);
            check("div1 WRAP", int'(if_c.WRAP), (k % 4 == 0) ? 1 : 0);
        end

        // reset mid-scan at idx=3
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            cyc();
            if (if_a.CUR == 2'd3) found = 1'b1;
        end
        check("wait idx3", int'(found), 1);
        #2 rst_l = 1'b0;
        #1;
        check("midscan rst Y_L", int'(if_a.Y_L), 'hF);
        check("midscan rst CUR", int'(if_a.CUR), 0);
        check("midscan rst WRAP", int'(if_a.WRAP), 0);
        cyc();
        rst_l = 1'b1;
        repeat (3) cyc();
        check("restart dwell CUR", int'(if_a.CUR), 0);
        check("restart dwell Y_L", int'(if_a.Y_L), 'hE);
        cyc();
        check("restart step CUR", int'(if_a.CUR), 1);

        // randomized traffic against the model
        for (int r = 0; r < 1500; r++) begin
            g_l = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_l = 1'b0;
                cyc();
                rst_l = 1'b1;
            end else begin
                cyc();
            end
        end

        cmp_on = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
